pt_check: RTL and testbench

PT_CHECK -- requirements
Module: pt_check

---
 rtl/pt_check.sv | 140 ++++++++++++++
 tb/tb_pt_check.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pt_check.sv
// pt_check: scans a length-prefixed plaintext buffer and reports whether every byte is printable.
// Latency: 2L+2 cycles from start to rdy for a full pass; 2k+2 cycles when byte k fails.
// Backpressure: en is accepted only while rdy=1; en seen while busy is dropped, not queued.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         start request, honoured only with rdy=1
//   rdy        idle / able to accept a start
//   pt_addr    registered read address into the plaintext RAM (read-only access)
//   pt_rddata  RAM read data, valid two edges after pt_addr changes
//   key_valid  last completed scan found only printable bytes
//   bad_addr   address of the first failing byte of the last scan, 0 if none
module pt_check #(
    parameter logic [7:0] LO_CHAR = 8'h20,
    parameter logic [7:0] HI_CHAR = 8'h7E
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       key_valid,
    output logic [7:0] bad_addr
);

    // RD_* is the cycle in which the RAM registers the new address;
    // WAIT_* is the cycle whose closing edge samples the returned data.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_LEN    = 3'd1,
        WAIT_LEN  = 3'd2,
        RD_BYTE   = 3'd3,
        WAIT_BYTE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] len_q,   len_d;
    logic       kv_q,    kv_d;
    logic [7:0] bad_q,   bad_d;

    logic       byte_ok;

    // Unsigned window compare; 8'h80 and above fail rather than looking negative.
    assign byte_ok = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        kv_d    = kv_q;
        bad_d   = bad_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RD_LEN;
                    addr_d  = 8'd0;
                    kv_d    = 1'b0;
                    bad_d   = 8'd0;
                end
            end

            RD_LEN: begin
                state_d = WAIT_LEN;
            end

            WAIT_LEN: begin
                len_d = pt_rddata;
                if (pt_rddata == 8'd0) begin
                    // Empty message is trivially printable.
                    state_d = IDLE;
                    kv_d    = 1'b1;
                end else begin
                    addr_d  = 8'd1;
                    state_d = RD_BYTE;
                end
            end

            RD_BYTE: begin
                state_d = WAIT_BYTE;
            end

            WAIT_BYTE: begin
                if (!byte_ok) begin
                    // Early abort: remaining bytes are never fetched.
                    state_d = IDLE;
                    kv_d    = 1'b0;
                    bad_d   = addr_q;
                end else if (addr_q == len_q) begin
                    // Last byte: address parks at L, so L=255 never wraps to 0.
                    state_d = IDLE;
                    kv_d    = 1'b1;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = RD_BYTE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 8'd0;
            len_q   <= 8'd0;
            kv_q    <= 1'b0;
            bad_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            kv_q    <= kv_d;
            bad_q   <= bad_d;
        end
    end

    // rdy decodes straight from the state register, so reset forces it high at once.
    assign rdy       = (state_q == IDLE);
    assign pt_addr   = addr_q;
    assign key_valid = kv_q;
    assign bad_addr  = bad_q;

`ifndef SYNTHESIS
    // Byte fetches stay within 1..L.
    a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RD_BYTE || state_q == WAIT_BYTE) |-> (addr_q != 8'd0 && addr_q <= len_q));

    // Results are frozen while idle unless a new scan is starting.
    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE && !en) |=> ($stable(kv_q) && $stable(bad_q)));
`endif

endmodule

// File: tb/tb_pt_check.sv
module tb_pt_check;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       key_valid;
    logic [7:0] bad_addr;

    logic [7:0] mem [256];
    bit         seen [256];

    int n_total;
    int n_bad;

    pt_check #(.LO_CHAR(8'h20), .HI_CHAR(8'h7E)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .key_valid (key_valid),
        .bad_addr  (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with registered address.
    always @(posedge clk) pt_rddata <= mem[pt_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Called just after a negedge with rdy=1. Pulses en for one edge, then
    // counts edges until rdy rises. en is raised again for one cycle at
    // cycle number toggle_at (0 = never) to probe the busy-ignore rule.
    // Returns at the negedge where rdy was first seen high.
    task automatic run_scan(input int toggle_at, output int cycles,
                            output int zero_after_len, output int addr_c2);
        int c;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        zero_after_len = 0;
        addr_c2 = -1;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        c = 0;
        seen[pt_addr] = 1'b1;
        while (!rdy && c < 700) begin
            @(negedge clk);
            c++;
            en = (toggle_at != 0 && c == toggle_at);
            seen[pt_addr] = 1'b1;
            if (c == 2) addr_c2 = pt_addr;
            if (c >= 2 && pt_addr == 8'd0) zero_after_len++;
        end
        en = 1'b0;
        if (!rdy) chk("scan_timeout", 0, 1);
        cycles = c;
    endtask

    initial begin
        int cyc, zc, a2;
        n_total = 0;
        n_bad   = 0;
        en      = 1'b0;
        rst_n   = 1'b0;
        clear_mem();

        // Reset state
        #12;
        chk("rst_rdy", rdy, 1);
        chk("rst_addr", pt_addr, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_bad", bad_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty message
        mem[0] = 8'h00;
        run_scan(0, cyc, zc, a2);
        chk("len0_cycles", cyc, 2);
        chk("len0_kv", key_valid, 1);
        chk("len0_bad", bad_addr, 0);

        // Two printable bytes; en toggled mid-scan must be ignored
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h48; mem[2] = 8'h69;
        run_scan(3, cyc, zc, a2);
        chk("hi_cycles", cyc, 6);
        chk("hi_kv", key_valid, 1);
        chk("hi_bad", bad_addr, 0);
        chk("hi_seen0", seen[0], 1);
        chk("hi_seen1", seen[1], 1);
        chk("hi_seen2", seen[2], 1);
        chk("hi_addr_c2", a2, 1);
        chk("hi_final_addr", pt_addr, 2);
        repeat (3) @(negedge clk);
        chk("busy_en_not_queued", rdy, 1);

        // Abort on 7F at address 2
        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'h41; mem[2] = 8'h7F; mem[3] = 8'h42;
        run_scan(0, cyc, zc, a2);
        chk("abort_cycles", cyc, 6);
        chk("abort_kv", key_valid, 0);
        chk("abort_bad", bad_addr, 2);
        chk("abort_no_addr3", seen[3], 0);
        repeat (5) @(negedge clk);
        chk("abort_bad_stable", bad_addr, 2);
        chk("abort_rdy_stable", rdy, 1);

        // Boundary: 20 and 7E pass
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h20; mem[2] = 8'h7E;
        run_scan(0, cyc, zc, a2);
        chk("bnd_pass_cycles", cyc, 6);
        chk("bnd_pass_kv", key_valid, 1);

        // Boundary: 1F fails
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h1F;
        run_scan(0, cyc, zc, a2);
        chk("bnd_1f_cycles", cyc, 4);
        chk("bnd_1f_kv", key_valid, 0);
        chk("bnd_1f_bad", bad_addr, 1);

        // Boundary: 80 fails (unsigned)
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h41; mem[2] = 8'h80;
        run_scan(0, cyc, zc, a2);
        chk("bnd_80_cycles", cyc, 6);
        chk("bnd_80_kv", key_valid, 0);
        chk("bnd_80_bad", bad_addr, 2);

        // Full 255-byte message, no wrap
        clear_mem();
        mem[0] = 8'hFF;
        for (int i = 1; i < 256; i++) mem[i] = 8'h41;
        run_scan(0, cyc, zc, a2);
        chk("max_cycles", cyc, 512);
        chk("max_kv", key_valid, 1);
        chk("max_addr", pt_addr, 8'hFF);
        chk("max_no_zero", zc, 0);

        // Reset mid-scan, then restart on first en edge
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h41; mem[2] = 8'h42;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("mid_busy", rdy, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", rdy, 1);
        chk("mid_rst_kv", key_valid, 0);
        chk("mid_rst_addr", pt_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_result_kv", key_valid, 0);
        chk("mid_no_result_rdy", rdy, 1);
        run_scan(0, cyc, zc, a2);
        chk("post_rst_cycles", cyc, 4 + 2);
        chk("post_rst_kv", key_valid, 1);

        // en held high: back-to-back scans
        clear_mem();
        mem[0] = 8'h00;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_busy1", rdy, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done1", rdy, 1);
        chk("b2b_kv1", key_valid, 1);
        @(negedge clk);
        chk("b2b_restart", rdy, 0);
        chk("b2b_kv_cleared", key_valid, 0);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done2", rdy, 1);
        chk("b2b_kv2", key_valid, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
